// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 op codes, FSM states, datapath width.
package muldiv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIN  = 3'd3,
    DONE = 3'd4
  } md_state_e;

  function automatic logic op_is_div(input md_op_e o);
    return o inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  function automatic logic op_is_rem(input md_op_e o);
    return o inside {MD_REM, MD_REMU};
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational sign handling: operand magnitudes and result sign on the way in,
// two's-complement correction of the raw 64-bit result on the way out.
module muldiv_sign_fix
  import muldiv_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] mag_a,
  output logic [31:0] mag_b,
  output logic        res_neg,
  input  logic [63:0] raw,
  input  logic        neg,
  output logic [63:0] fixed
);

  logic a_signed;
  logic b_signed;

  always_comb begin
    a_signed = op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    b_signed = op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
    mag_a    = (a_signed && a[31]) ? (~a + 32'd1) : a;
    mag_b    = (b_signed && b[31]) ? (~b + 32'd1) : b;
    // Remainder takes the dividend's sign; MULHSU only has a signed rs1.
    case (op)
      MD_MUL, MD_MULH, MD_DIV: res_neg = a[31] ^ b[31];
      MD_MULHSU, MD_REM:       res_neg = a[31];
      default:                 res_neg = 1'b0;
    endcase
    fixed = neg ? (~raw + 64'd1) : raw;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide, one bit per cycle,
// busy stalls the core and done pulses with the registered result.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  import muldiv_pkg::*;

  md_state_e         state, state_nx;
  md_op_e            op_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic [2*XLEN-1:0] acc, opa;
  logic [XLEN-1:0]   opb;
  logic [CNT_W-1:0]  counter;
  logic              neg_q, spec_q;
  logic [XLEN-1:0]   spec_res;

  logic [XLEN-1:0]   mag_a, mag_b;
  logic              res_neg;
  logic [2*XLEN-1:0] raw, fixed;

  logic              is_div, is_rem, div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_val, fin_val;
  logic [2*XLEN-1:0] mul_acc_nx;
  logic [XLEN:0]     r_sh;
  logic [XLEN+1:0]   diff;
  logic              ge;

  muldiv_sign_fix u_sign_fix (
    .op      (op_q),
    .a       (a_q),
    .b       (b_q),
    .mag_a   (mag_a),
    .mag_b   (mag_b),
    .res_neg (res_neg),
    .raw     (raw),
    .neg     (neg_q),
    .fixed   (fixed)
  );

  always_comb begin
    is_div   = op_is_div(op_q);
    is_rem   = op_is_rem(op_q);
    div_zero = (b_q == '0);
    div_ovf  = (op_q == MD_DIV || op_q == MD_REM) &&
               (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
    special  = is_div && (div_zero || div_ovf);
    if (div_zero)
      special_val = is_rem ? a_q : '1;
    else
      special_val = is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};

    mul_acc_nx = opb[0] ? (acc + opa) : acc;
    // Restoring step: shift next dividend bit into the partial remainder, subtract if it fits.
    r_sh = {acc[XLEN-1:0], opa[XLEN-1]};
    diff = {1'b0, r_sh} - {2'b00, opb};
    ge   = ~diff[XLEN+1];

    if (!is_div)
      raw = acc;
    else if (is_rem)
      raw = {{XLEN{1'b0}}, acc[XLEN-1:0]};
    else
      raw = {{XLEN{1'b0}}, opa[XLEN-1:0]};

    if (spec_q)
      fin_val = special_val;
    else if (is_div || op_q == MD_MUL)
      fin_val = fixed[XLEN-1:0];
    else
      fin_val = fixed[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = PREP;
      // Special cases skip the iteration; FIN still registers their result.
      PREP: state_nx = special ? FIN : CALC;
      CALC: if (counter == CNT_W'(1)) state_nx = FIN;
      FIN:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= MD_MUL;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      opa      <= '0;
      opb      <= '0;
      counter  <= '0;
      neg_q    <= 1'b0;
      spec_q   <= 1'b0;
      spec_res <= '0;
      result   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= md_op_e'(op);
          end
        end
        PREP: begin
          acc      <= '0;
          opa      <= {{XLEN{1'b0}}, mag_a};
          opb      <= mag_b;
          neg_q    <= res_neg;
          spec_q   <= special;
          spec_res <= special_val;
          if (!special) counter <= CNT_W'(XLEN);
        end
        CALC: begin
          counter <= counter - CNT_W'(1);
          if (is_div) begin
            acc <= ge ? {{(XLEN-1){1'b0}}, diff[XLEN:0]}
                      : {{XLEN{1'b0}}, r_sh[XLEN-1:0]};
            opa <= {{XLEN{1'b0}}, opa[XLEN-2:0], ge};
          end else begin
            acc <= mul_acc_nx;
            opa <= opa << 1;
            opb <= opb >> 1;
          end
        end
        FIN: result <= fin_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit with hand-computed results and latencies.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;

  muldiv_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Drives a one-cycle start; returns #1 after the sampling edge (edge 0).
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns the edge count after which done was seen (-1 on timeout), the result and busy
  // at that point, then steps one more edge so the unit is back in IDLE.
  task automatic wait_done(output logic [31:0] r, output int n, output logic bsy);
    n = -1; r = '0; bsy = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = i; r = result; bsy = busy;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL reset_result: got %h expected 0", result); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mul();
    logic [31:0] r; int n; logic bsy;
    issue(OP_MUL, 32'd7, 32'hFFFFFFFD);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mul_busy_start: got %b expected 1", busy); end
    wait_done(r, n, bsy);
    n_cmp++; if (r !== 32'hFFFFFFEB) begin n_bad++; $display("FAIL mul_result: got %h expected ffffffeb", r); end
    n_cmp++; if (n !== 34) begin n_bad++; $display("FAIL mul_latency: got %0d expected 34", n); end
    n_cmp++; if (bsy !== 1'b1) begin n_bad++; $display("FAIL mul_busy_done: got %b expected 1", bsy); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mul_busy_after: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL mul_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_mulh_family();
    logic [2:0]  to [3] = '{OP_MULH, OP_MULHU, OP_MULHSU};
    logic [31:0] ta [3] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] tb [3] = '{32'h80000000, 32'hFFFFFFFF, 32'h00000002};
    logic [31:0] te [3] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
    logic [31:0] r; int n; logic bsy;
    for (int i = 0; i < 3; i++) begin
      issue(to[i], ta[i], tb[i]);
      wait_done(r, n, bsy);
      n_cmp++; if (r !== te[i]) begin n_bad++; $display("FAIL mulh[%0d]_result: got %h expected %h", i, r, te[i]); end
      n_cmp++; if (n !== 34) begin n_bad++; $display("FAIL mulh[%0d]_latency: got %0d expected 34", i, n); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  to [4] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU};
    logic [31:0] ta [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
    logic [31:0] tb [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] te [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
    logic [31:0] r; int n; logic bsy;
    for (int i = 0; i < 4; i++) begin
      issue(to[i], ta[i], tb[i]);
      wait_done(r, n, bsy);
      n_cmp++; if (r !== te[i]) begin n_bad++; $display("FAIL div[%0d]_result: got %h expected %h", i, r, te[i]); end
      n_cmp++; if (n !== 34) begin n_bad++; $display("FAIL div[%0d]_latency: got %0d expected 34", i, n); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  to [6] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM};
    logic [31:0] ta [6] = '{32'h1234, 32'h1234, 32'h1234, 32'h1234, 32'h80000000, 32'h80000000};
    logic [31:0] tb [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] te [6] = '{32'hFFFFFFFF, 32'h1234, 32'hFFFFFFFF, 32'h1234, 32'h80000000, 32'h0};
    logic [31:0] r; int n; logic bsy;
    for (int i = 0; i < 6; i++) begin
      issue(to[i], ta[i], tb[i]);
      wait_done(r, n, bsy);
      n_cmp++; if (r !== te[i]) begin n_bad++; $display("FAIL special[%0d]_result: got %h expected %h", i, r, te[i]); end
      n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL special[%0d]_latency: got %0d expected 2", i, n); end
    end
  endtask

  task automatic test_start_ignored();
    logic [31:0] r = '0; int n = -1; int pulses = 0;
    issue(OP_DIVU, 32'd100, 32'd7);
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        pulses++;
        if (n < 0) begin n = i; r = result; end
      end
      if (i == 5) begin start = 1'b1; op = OP_MUL; a = 32'd5; b = 32'd9; end
      if (i == 6) start = 1'b0;
      if (n > 0 && i >= n + 3) break;
    end
    n_cmp++; if (r !== 32'd14) begin n_bad++; $display("FAIL ignore_result: got %h expected 0000000e", r); end
    n_cmp++; if (n !== 34) begin n_bad++; $display("FAIL ignore_latency: got %0d expected 34", n); end
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL ignore_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] r; int n; logic bsy; int pulses = 0;
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL abort_result: got %h expected 0", result); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d expected 0", pulses); end
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done(r, n, bsy);
    n_cmp++; if (r !== 32'hFFFFFFFD) begin n_bad++; $display("FAIL abort_next_result: got %h expected fffffffd", r); end
    n_cmp++; if (n !== 34) begin n_bad++; $display("FAIL abort_next_latency: got %0d expected 34", n); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r = '0; int n = -1; logic bsy;
    issue(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk);
      #1;
      if (done) begin n = i; r = result; break; end
    end
    n_cmp++; if (r !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL b2b_first_result: got %h expected fffffffe", r); end
    start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
    @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_start_in_done: got busy %b expected 0", busy); end
    @(posedge clk);
    #1 start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept: got busy %b expected 1", busy); end
    wait_done(r, n, bsy);
    n_cmp++; if (r !== 32'd14) begin n_bad++; $display("FAIL b2b_second_result: got %h expected 0000000e", r); end
    n_cmp++; if (n !== 34) begin n_bad++; $display("FAIL b2b_second_latency: got %0d expected 34", n); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh_family();
    test_div();
    test_special();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
